// File: rtl/modulated_delay.sv
// modulated_delay: LFO-modulated multi-tap delay line (vibrato / chorus).
// Each voice reads a delayed sample from external SRAM at an offset swept by
// a triangle LFO. The voices are averaged and then either replace the dry
// sample (vibrato) or are mixed 50/50 with it (chorus).
// Optional build macro: MODDELAY_INTERP_EN enables linear interpolation
// between two adjacent delay-line samples (two SRAM reads per voice).
module modulated_delay #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 13,
    parameter int NUM_VOICES  = 2,
    parameter int PHASE_WIDTH = 24,
    parameter int BASE_DELAY  = 240
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cs,
    input  logic                  my_turn,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  modfreq_control_key,
    input  logic                  depth_control_key,
    input  logic                  mode_control_key,
    input  logic [DATA_WIDTH-1:0] sram_data_in,
    input  logic                  sram_read_finish,
    output logic                  sram_rd,
    output logic [ADDR_WIDTH-1:0] sram_offset,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] data_out
);

    localparam int unsigned VSHIFT = $clog2(NUM_VOICES);
    localparam logic [PHASE_WIDTH-1:0] VOICE_STEP =
        PHASE_WIDTH'((64'd1 << PHASE_WIDTH) / NUM_VOICES);
    localparam logic [1:0] LAST_V = 2'(NUM_VOICES - 1);

    typedef enum logic [2:0] {IDLE, CALC, READ, ACCUM, MIX, DONE} state_t;
    state_t state, state_nx;

    logic [2:0]                    rate_opt;
    logic [1:0]                    depth_opt;
    logic                          mode_opt;
    logic [PHASE_WIDTH-1:0]        phase;
    logic [11:0]                   inc_l;
    logic [8:0]                    depth_l;
    logic                          mode_l;
    logic signed [DATA_WIDTH-1:0]  dry;
    logic signed [DATA_WIDTH-1:0]  s0;
    logic [1:0]                    vidx;
    logic signed [DATA_WIDTH+1:0]  wet_sum;
    logic                          start;

    logic [PHASE_WIDTH-1:0]        pv;
    logic [15:0]                   tri_raw;
    logic [15:0]                   tri_v;
    logic [25:0]                   prod;
    logic [ADDR_WIDTH-1:0]         d_calc;
    logic signed [DATA_WIDTH+1:0]  voice_smp;
    logic signed [DATA_WIDTH+1:0]  wet_full;
    logic signed [DATA_WIDTH-1:0]  wet;
    logic signed [DATA_WIDTH-1:0]  mix_val;

`ifdef MODDELAY_INTERP_EN
    logic [ADDR_WIDTH-1:0]         d_int;
    logic [7:0]                    frac;
    logic [7:0]                    frac_calc;
    logic signed [DATA_WIDTH-1:0]  s1;
    logic                          second;
    logic signed [DATA_WIDTH:0]    diff;
    logic signed [DATA_WIDTH+9:0]  scaled;
`endif

    function automatic logic [11:0] rate_inc(input logic [2:0] opt);
        case (opt)
            3'd0:    return 12'd350;
            3'd1:    return 12'd699;
            3'd2:    return 12'd1049;
            3'd3:    return 12'd1398;
            3'd4:    return 12'd1748;
            3'd5:    return 12'd2097;
            3'd6:    return 12'd2796;
            default: return 12'd3495;
        endcase
    endfunction

    function automatic logic [8:0] depth_val(input logic [1:0] opt);
        case (opt)
            2'd0:    return 9'd48;
            2'd1:    return 9'd96;
            2'd2:    return 9'd192;
            default: return 9'd384;
        endcase
    endfunction

    assign start = cs && my_turn;
    assign done  = (state == DONE);

    // User option registers: each key pulse steps its option, wrapping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rate_opt  <= '0;
            depth_opt <= '0;
            mode_opt  <= 1'b0;
        end else begin
            if (modfreq_control_key) rate_opt  <= rate_opt + 3'd1;
            if (depth_control_key)   depth_opt <= depth_opt + 2'd1;
            if (mode_control_key)    mode_opt  <= ~mode_opt;
        end
    end

    // Voice phase, triangle LFO, delay and (optionally) interpolated sample
    always_comb begin
        pv       = phase + PHASE_WIDTH'(vidx) * VOICE_STEP;
        tri_raw  = 16'(pv >> (PHASE_WIDTH - 17));
        tri_v    = pv[PHASE_WIDTH-1] ? ~tri_raw : tri_raw;
        prod     = 26'(depth_l) * 26'(tri_v);
        d_calc   = ADDR_WIDTH'(BASE_DELAY) + ADDR_WIDTH'(prod >> 16);
`ifdef MODDELAY_INTERP_EN
        frac_calc = 8'(prod >> 8);
        diff      = {s1[DATA_WIDTH-1], s1} - {s0[DATA_WIDTH-1], s0};
        scaled    = $signed({{9{diff[DATA_WIDTH]}}, diff})
                  * $signed({{(DATA_WIDTH+2){1'b0}}, frac});
        voice_smp = $signed({{2{s0[DATA_WIDTH-1]}}, s0})
                  + (DATA_WIDTH+2)'(scaled >>> 8);
`else
        voice_smp = {{2{s0[DATA_WIDTH-1]}}, s0};
`endif
        wet_full = wet_sum >>> VSHIFT;
        wet      = DATA_WIDTH'(wet_full);
        mix_val  = mode_l ? (dry >>> 1) + (wet >>> 1) : wet;
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (start) state_nx = CALC;
            CALC:  state_nx = READ;
`ifdef MODDELAY_INTERP_EN
            READ:  if (sram_read_finish && second) state_nx = ACCUM;
`else
            READ:  if (sram_read_finish) state_nx = ACCUM;
`endif
            ACCUM: state_nx = (vidx == LAST_V) ? MIX : CALC;
            MIX:   state_nx = DONE;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: sample latch, SRAM requests, accumulation, mix and LFO step
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase       <= '0;
            inc_l       <= '0;
            depth_l     <= '0;
            mode_l      <= 1'b0;
            dry         <= '0;
            s0          <= '0;
            vidx        <= '0;
            wet_sum     <= '0;
            sram_rd     <= 1'b0;
            sram_offset <= '0;
            data_out    <= '0;
`ifdef MODDELAY_INTERP_EN
            d_int       <= '0;
            frac        <= '0;
            s1          <= '0;
            second      <= 1'b0;
`endif
        end else begin
            sram_rd <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dry     <= $signed(data_in);
                        inc_l   <= rate_inc(rate_opt);
                        depth_l <= depth_val(depth_opt);
                        mode_l  <= mode_opt;
                        vidx    <= '0;
                        wet_sum <= '0;
                    end
                end
                CALC: begin
                    sram_rd     <= 1'b1;
                    sram_offset <= {d_calc[ADDR_WIDTH-2:0], 1'b0};
`ifdef MODDELAY_INTERP_EN
                    d_int       <= d_calc;
                    frac        <= frac_calc;
                    second      <= 1'b0;
`endif
                end
                READ: begin
                    if (sram_read_finish) begin
`ifdef MODDELAY_INTERP_EN
                        // first return is s0 and launches the s1 read at the next sample
                        if (!second) begin
                            s0          <= $signed(sram_data_in);
                            second      <= 1'b1;
                            sram_rd     <= 1'b1;
                            sram_offset <= {d_int[ADDR_WIDTH-2:0] + (ADDR_WIDTH-1)'(1), 1'b0};
                        end else begin
                            s1 <= $signed(sram_data_in);
                        end
`else
                        s0 <= $signed(sram_data_in);
`endif
                    end
                end
                ACCUM: begin
                    wet_sum <= wet_sum + voice_smp;
                    if (vidx != LAST_V) vidx <= vidx + 2'd1;
                end
                MIX: begin
                    data_out <= mix_val;
                end
                DONE: begin
                    phase <= phase + PHASE_WIDTH'(inc_l);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_modulated_delay.sv
// Testbench for modulated_delay: two instances (1 and 2 voices) share stimulus
// and a behavioural SRAM; a reference model predicts data_out per sample and
// a scoreboard queue per instance holds expectations until done.
module tb_modulated_delay;

    logic        clk = 1'b0;
    logic        rst, cs, my_turn;
    logic [15:0] data_in;
    logic        mkey, dkey, modekey;
    logic [15:0] sd1, sd2;
    logic        fin1, fin2;
    logic        rd1, rd2, done1, done2;
    logic [12:0] off1, off2;
    logic [15:0] out1, out2;

    always #5 clk = ~clk;

    modulated_delay #(.NUM_VOICES(1)) u1 (
        .clk(clk), .rst(rst), .cs(cs), .my_turn(my_turn), .data_in(data_in),
        .modfreq_control_key(mkey), .depth_control_key(dkey),
        .mode_control_key(modekey), .sram_data_in(sd1),
        .sram_read_finish(fin1), .sram_rd(rd1), .sram_offset(off1),
        .done(done1), .data_out(out1)
    );

    modulated_delay #(.NUM_VOICES(2)) u2 (
        .clk(clk), .rst(rst), .cs(cs), .my_turn(my_turn), .data_in(data_in),
        .modfreq_control_key(mkey), .depth_control_key(dkey),
        .mode_control_key(modekey), .sram_data_in(sd2),
        .sram_read_finish(fin2), .sram_rd(rd2), .sram_offset(off2),
        .done(done2), .data_out(out2)
    );

    int tot = 0;
    int bad = 0;
    int mem [0:4095];
    int q1 [$];
    int q2 [$];
    int offq1 [$];
    int rdc1 = 0, rdc2 = 0, dn1 = 0, dn2 = 0;
    int tb_phase = 0, tb_rate = 0, tb_depth = 0, tb_mode = 0;
    int rate_tab [8] = '{350, 699, 1049, 1398, 1748, 2097, 2796, 3495};
    int depth_tab [4] = '{48, 96, 192, 384};
    logic inj = 1'b0;
    bit   pend1 = 0, pend2 = 0;
    int   cnt1, cnt2;
    logic [12:0] ro1, ro2;

    task automatic check_eq(input string tag, input int act, input int exp);
        tot++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, act, act, exp, exp);
        end
    endtask

    function automatic int model(input int nv, input int dry, input int dep,
                                 input int md, input int ph);
        int sum, sh, pv, tv, pr, d, fr, smp, wet, res;
        sum = 0;
        sh  = (nv == 1) ? 0 : (nv == 2) ? 1 : 2;
        for (int v = 0; v < nv; v++) begin
            pv = (ph + v * ((1 << 24) / nv)) & 'hFFFFFF;
            tv = (pv >> 7) & 'hFFFF;
            if ((pv & 'h800000) != 0) tv = (~tv) & 'hFFFF;
            pr  = depth_tab[dep] * tv;
            d   = 240 + ((pr >> 16) & 1023);
            fr  = (pr >> 8) & 255;
            smp = mem[d];
`ifdef MODDELAY_INTERP_EN
            smp = mem[d] + (((mem[d+1] - mem[d]) * fr) >>> 8);
`endif
            sum += smp;
        end
        wet = sum >>> sh;
        res = (md != 0) ? ((dry >>> 1) + (wet >>> 1)) : wet;
        return res & 'hFFFF;
    endfunction

    // SRAM responders: random 0..2 extra cycles of latency per read
    always @(negedge clk) begin
        fin1 = 1'b0;
        if (rst !== 1'b1) pend1 = 0;
        else begin
            if (pend1) begin
                if (cnt1 == 0) begin
                    fin1 = 1'b1; sd1 = 16'(mem[ro1 >> 1]); pend1 = 0;
                end else cnt1--;
            end
            if (inj) begin fin1 = 1'b1; sd1 = 16'h7777; end
            if (rd1) begin
                pend1 = 1; ro1 = off1; cnt1 = $urandom_range(0, 2);
                rdc1++; offq1.push_back(int'(off1));
            end
        end
    end

    always @(negedge clk) begin
        fin2 = 1'b0;
        if (rst !== 1'b1) pend2 = 0;
        else begin
            if (pend2) begin
                if (cnt2 == 0) begin
                    fin2 = 1'b1; sd2 = 16'(mem[ro2 >> 1]); pend2 = 0;
                end else cnt2--;
            end
            if (inj) begin fin2 = 1'b1; sd2 = 16'h7777; end
            if (rd2) begin
                pend2 = 1; ro2 = off2; cnt2 = $urandom_range(0, 2);
                rdc2++;
            end
        end
    end

    // Scoreboard pop on done
    always @(negedge clk) begin
        if (rst === 1'b1 && done1 === 1'b1) begin
            dn1++;
            if (q1.size() == 0) check_eq("u1 done without sample", q1.size(), 1);
            else check_eq("u1 data_out", int'(out1), q1.pop_front());
        end
        if (rst === 1'b1 && done2 === 1'b1) begin
            dn2++;
            if (q2.size() == 0) check_eq("u2 done without sample", q2.size(), 1);
            else check_eq("u2 data_out", int'(out2), q2.pop_front());
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic key(input int which);
        if (which == 0) begin mkey = 1'b1; tb_rate = (tb_rate + 1) % 8; end
        if (which == 1) begin dkey = 1'b1; tb_depth = (tb_depth + 1) % 4; end
        if (which == 2) begin modekey = 1'b1; tb_mode = 1 - tb_mode; end
        tick(1);
        mkey = 1'b0; dkey = 1'b0; modekey = 1'b0;
    endtask

    task automatic start_sample(input logic [15:0] dry);
        int dsx;
        dsx = int'($signed(dry));
        data_in = dry; cs = 1'b1; my_turn = 1'b1;
        q1.push_back(model(1, dsx, tb_depth, tb_mode, tb_phase));
        q2.push_back(model(2, dsx, tb_depth, tb_mode, tb_phase));
        tick(1);
        cs = 1'b0; my_turn = 1'b0;
        tb_phase = (tb_phase + rate_tab[tb_rate]) & 'hFFFFFF;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q1.size() != 0 || q2.size() != 0) && n < 300) begin
            tick(1); n++;
        end
        check_eq("sample completes", q1.size() + q2.size(), 0);
        q1.delete(); q2.delete();
        tick(2);
    endtask

    task automatic fill_random();
        for (int i = 0; i < 4096; i++) mem[i] = int'($urandom_range(0, 65535)) - 32768;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, rb1, db1, db2, ek;
        rst = 1'b0; cs = 1'b0; my_turn = 1'b0; data_in = '0;
        mkey = 1'b0; dkey = 1'b0; modekey = 1'b0;
        fill_random();
        tick(3);
        check_eq("reset done u1", int'(done1), 0);
        check_eq("reset sram_rd u1", int'(rd1), 0);
        check_eq("reset offset u1", int'(off1), 0);
        check_eq("reset data_out u1", int'(out1), 0);
        check_eq("reset done u2", int'(done2), 0);
        check_eq("reset data_out u2", int'(out2), 0);
        rst = 1'b1;
        tick(2);

        // options 0, phase 0: single read at offset 480
        mem[240] = 'h1234;
        offq1.delete();
        start_sample(16'h0100);
        wait_idle();
        check_eq("u1 first offset", (offq1.size() > 0) ? offq1[0] : -1, 480);
        check_eq("u1 out 0x1234", int'(out1), 'h1234);
        check_eq("u1 phase after 1", int'(u1.phase), 350);
        check_eq("u1 one done", dn1, 1);
        tick(5);
        check_eq("u1 data_out hold", int'(out1), 'h1234);

        // depth 384 at phase 350: tri 2, frac 3
        key(1); key(1); key(1);
        mem[240] = 0; mem[241] = 1000;
        offq1.delete();
        start_sample(16'h0000);
        wait_idle();
`ifdef MODDELAY_INTERP_EN
        ek = 11;
        check_eq("u1 second read offset", (offq1.size() > 1) ? offq1[1] : -1, 482);
`else
        ek = 0;
        check_eq("u1 read count", offq1.size(), 1);
`endif
        check_eq("u1 interp/plain value", int'(out1), ek);

        // chorus mix
        key(2);
        for (int i = 0; i < 4096; i++) mem[i] = 'h0800;
        start_sample(16'h1000);
        wait_idle();
        check_eq("u2 chorus", int'(out2), 'h0C00);
        check_eq("u1 chorus", int'(out1), 'h0C00);
        fill_random();

        // my_turn while busy is ignored
        db1 = dn1; db2 = dn2;
        start_sample(16'h2345);
        tick(2);
        cs = 1'b1; my_turn = 1'b1; tick(1); cs = 1'b0; my_turn = 1'b0;
        wait_idle();
        tick(10);
        check_eq("u1 single done", dn1 - db1, 1);
        check_eq("u2 single done", dn2 - db2, 1);

        // randomised samples and option changes
        for (int it = 0; it < 24; it++) begin
            n = $urandom_range(0, 4);
            if (n < 3) key(n);
            start_sample(16'($urandom_range(0, 65535)));
            wait_idle();
        end

        // reset in the middle of a read
        start_sample(16'h4321);
        n = 0;
        while (rd1 !== 1'b1 && n < 50) begin tick(1); n++; end
        check_eq("u1 read issued", int'(rd1), 1);
        db1 = dn1;
        rst = 1'b0;
        #1;
        check_eq("midreset done u1", int'(done1), 0);
        check_eq("midreset sram_rd u1", int'(rd1), 0);
        check_eq("midreset data_out u1", int'(out1), 0);
        check_eq("midreset data_out u2", int'(out2), 0);
        q1.delete(); q2.delete();
        tb_phase = 0; tb_rate = 0; tb_depth = 0; tb_mode = 0;
        tick(2);
        rst = 1'b1;
        rb1 = rdc1;
        tick(1);
        inj = 1'b1; tick(1); inj = 1'b0;
        tick(10);
        check_eq("no read after reset", rdc1 - rb1, 0);
        check_eq("no done after reset", dn1 - db1, 0);

        // eight rate pulses wrap to option 0
        for (int i = 0; i < 8; i++) key(0);
        start_sample(16'h0111);
        wait_idle();
        start_sample(16'h0222);
        wait_idle();
        check_eq("u1 phase after wrap", int'(u1.phase), 700);
        check_eq("u2 phase after wrap", int'(u2.phase), tb_phase);

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
